// File: rtl/rgb_pkg.sv
// Shared constants for the RGB PWM controller: colour component indices
// within a channel and the button mode encoding.
package rgb_pkg;

    localparam int RGB_B = 0;
    localparam int RGB_G = 1;
    localparam int RGB_R = 2;

    typedef enum logic {
        MODE_HOLD   = 1'b0,
        MODE_TOGGLE = 1'b1
    } mode_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-count debouncer and a
// registered one-cycle pulse on the cycle after the debounced level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_100mhz,
    input  logic rst,
    input  logic raw_in,
    output logic stable_out,
    output logic rise_pulse_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            sync_p0        <= 1'b0;
            sync_p1        <= 1'b0;
            stable_out     <= 1'b0;
            stable_d       <= 1'b0;
            rise_pulse_out <= 1'b0;
            cnt            <= '0;
        end else begin
            // synchroniser boundary
            sync_p0        <= raw_in;
            sync_p1        <= sync_p0;
            stable_d       <= stable_out;
            rise_pulse_out <= stable_out & ~stable_d;
            // any disagreement that does not persist for the full window restarts the count
            if (sync_p1 == stable_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable_out <= sync_p1;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel RGB LED controller: debounced buttons gate each LED, colour is
// latched from the switches on press and rendered through a shared PWM counter.
module rgb_pwm_ctrl
    import rgb_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int LVL_W           = 2,
    parameter int PWM_W           = 8,
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk_100mhz,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   btn,
    input  logic [SW_W-1:0]     sw,
    input  logic                toggle_mode,
    output logic [3*NUM_CH-1:0] rgb,
    output logic [SW_W-1:0]     led,
    output logic [NUM_CH-1:0]   ch_on
);

    localparam int COL_W = 3 * LVL_W;

    logic [NUM_CH-1:0] stable;
    logic [NUM_CH-1:0] press;
    mode_e             mode_p0;
    mode_e             mode_p1;
    logic              mode_chg;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [COL_W-1:0]  col [NUM_CH];

    // Full-scale level bypasses the compare so the output never drops at wrap.
    function automatic logic comp_on(input logic [LVL_W-1:0] lvl,
                                     input logic [PWM_W-1:0] cnt);
        logic [PWM_W-1:0] duty;
        duty = PWM_W'(lvl) << (PWM_W - LVL_W);
        return (lvl == '1) || (cnt < duty);
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_100mhz    (clk_100mhz),
            .rst           (rst),
            .raw_in        (btn[i]),
            .stable_out    (stable[i]),
            .rise_pulse_out(press[i])
        );
    end

    assign mode_chg = (mode_p0 != mode_p1);

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            led     <= '0;
            mode_p0 <= MODE_HOLD;
            mode_p1 <= MODE_HOLD;
            pwm_cnt <= '0;
            ch_on   <= '0;
            rgb     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                col[i] <= '0;
            end
        end else begin
            // input register boundary
            led     <= sw;
            mode_p0 <= mode_e'(toggle_mode);
            mode_p1 <= mode_p0;
            pwm_cnt <= pwm_cnt + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (press[i]) begin
                    col[i] <= led[i*COL_W +: COL_W];
                end
                // a press landing on a mode change still latches colour but not state
                if (mode_chg) begin
                    ch_on[i] <= 1'b0;
                end else if (mode_p0 == MODE_TOGGLE) begin
                    ch_on[i] <= ch_on[i] ^ press[i];
                end else begin
                    ch_on[i] <= stable[i];
                end
                // output register boundary
                rgb[3*i+RGB_B] <= ch_on[i] && comp_on(col[i][RGB_B*LVL_W +: LVL_W], pwm_cnt);
                rgb[3*i+RGB_G] <= ch_on[i] && comp_on(col[i][RGB_G*LVL_W +: LVL_W], pwm_cnt);
                rgb[3*i+RGB_R] <= ch_on[i] && comp_on(col[i][RGB_R*LVL_W +: LVL_W], pwm_cnt);
            end
        end
    end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed-sequence bench for rgb_pwm_ctrl with randomized colours; duty counts
// and latencies are predicted from the behavioural rules, not the RTL structure.
module tb_rgb_pwm_ctrl;

    localparam int NUM_CH = 2;
    localparam int LVL_W  = 2;
    localparam int PWM_W  = 4;
    localparam int SW_W   = 16;
    localparam int DEB    = 4;
    localparam int PERIOD = 1 << PWM_W;
    localparam int MAXLVL = (1 << LVL_W) - 1;
    localparam int ON_LAT = 2 + DEB + 1;

    logic                clk_100mhz = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_CH-1:0]   btn = '0;
    logic [SW_W-1:0]     sw = '0;
    logic                toggle_mode = 1'b0;
    logic [3*NUM_CH-1:0] rgb;
    logic [SW_W-1:0]     led;
    logic [NUM_CH-1:0]   ch_on;

    int tests = 0;
    int fails = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    rgb_pwm_ctrl #(
        .NUM_CH         (NUM_CH),
        .LVL_W          (LVL_W),
        .PWM_W          (PWM_W),
        .SW_W           (SW_W),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .btn        (btn),
        .sw         (sw),
        .toggle_mode(toggle_mode),
        .rgb        (rgb),
        .led        (led),
        .ch_on      (ch_on)
    );

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // High cycles per PWM period: level/(2^LVL_W) of the period, full scale is always on.
    function automatic int exp_cnt(input int lvl);
        if (lvl == MAXLVL) return PERIOD;
        return (lvl * PERIOD) / (1 << LVL_W);
    endfunction

    task automatic wait_ch(input int ch, input logic val, output int k);
        k = -1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (ch_on[ch] === val) begin
                k = j;
                break;
            end
        end
    endtask

    task automatic check_colour(input string pfx, input int ch, input logic [5:0] c);
        int cr, cg, cb;
        cr = 0; cg = 0; cb = 0;
        repeat (PERIOD) begin
            tick();
            if (rgb[3*ch+2]) cr++;
            if (rgb[3*ch+1]) cg++;
            if (rgb[3*ch])   cb++;
        end
        check({pfx, "_r"}, cr, exp_cnt(int'(c[5:4])));
        check({pfx, "_g"}, cg, exp_cnt(int'(c[3:2])));
        check({pfx, "_b"}, cb, exp_cnt(int'(c[1:0])));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k, bad;
        logic [5:0] c0, c1;

        repeat (3) tick();
        check("rst_rgb", 32'(rgb), 0);
        check("rst_led", 32'(led), 0);
        check("rst_ch_on", 32'(ch_on), 0);
        rst = 1'b0;
        sw = 16'hA5F0;
        tick();
        check("led_copy", 32'(led), 32'hA5F0);
        bad = 0;
        repeat (8) begin
            tick();
            if (rgb !== '0 || ch_on !== '0) bad++;
        end
        check("idle_dark", bad, 0);

        // hold mode on channel 0
        for (int it = 0; it < 3; it++) begin
            c0 = (it == 0) ? 6'b11_00_01 : 6'($urandom);
            sw = 16'($urandom);
            sw[5:0] = c0;
            btn[0] = 1'b1;
            wait_ch(0, 1'b1, k);
            check("hold_on_lat", k, ON_LAT);
            tick();
            check_colour("hold", 0, c0);
            check("hold_ch1_off", 32'(ch_on[1]), 0);
            btn[0] = 1'b0;
            wait_ch(0, 1'b0, k);
            check("hold_off_lat", k, ON_LAT);
            tick();
            check("hold_dark", 32'(rgb[2:0]), 0);
        end

        // bouncing button never qualifies
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            btn[1] = !j[1];
            tick();
            if (ch_on[1] !== 1'b0) bad++;
        end
        btn[1] = 1'b0;
        repeat (10) begin
            tick();
            if (ch_on[1] !== 1'b0) bad++;
        end
        check("bounce_no_on", bad, 0);

        // toggle mode on channel 1
        toggle_mode = 1'b1;
        repeat (3) tick();
        for (int it = 0; it < 2; it++) begin
            c1 = (it == 0) ? 6'b10_10_10 : 6'($urandom);
            sw = 16'($urandom);
            sw[11:6] = c1;
            btn[1] = 1'b1;
            wait_ch(1, 1'b1, k);
            check("tog_on_lat", k, ON_LAT + 1);
            repeat (4) tick();
            btn[1] = 1'b0;
            repeat (10) tick();
            check("tog_stays_on", 32'(ch_on[1]), 1);
            check_colour("tog", 1, c1);
            sw = 16'($urandom);
            repeat (2) tick();
            check_colour("tog_sw_change", 1, c1);
            check("tog_ch0_dark", 32'(rgb[2:0]), 0);
            btn[1] = 1'b1;
            wait_ch(1, 1'b0, k);
            check("tog_off_lat", k, ON_LAT + 1);
            repeat (4) tick();
            btn[1] = 1'b0;
            repeat (10) tick();
            check("tog_off_ch", 32'(ch_on[1]), 0);
            check("tog_off_rgb", 32'(rgb[5:3]), 0);
        end

        // simultaneous presses, then a mode change clears both
        sw = 16'($urandom);
        c0 = sw[5:0];
        c1 = sw[11:6];
        btn = 2'b11;
        wait_ch(0, 1'b1, k);
        check("simul_lat", k, ON_LAT + 1);
        check("simul_both", 32'(ch_on), 32'h3);
        repeat (4) tick();
        btn = 2'b00;
        repeat (10) tick();
        check_colour("simul_ch0", 0, c0);
        check_colour("simul_ch1", 1, c1);
        toggle_mode = 1'b0;
        tick();
        check("mode_chg_t1", 32'(ch_on), 32'h3);
        tick();
        check("mode_chg_clear", 32'(ch_on), 0);
        tick();
        check("mode_chg_dark", 32'(rgb), 0);

        // reset while lit and btn[0] held
        sw = 16'($urandom) | 16'h8000;
        btn = 2'b11;
        repeat (10) tick();
        check("pre_rst_lit", 32'(ch_on), 32'h3);
        btn[1] = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst_rgb", 32'(rgb), 0);
        check("mid_rst_led", 32'(led), 0);
        check("mid_rst_ch_on", 32'(ch_on), 0);
        rst = 1'b0;
        wait_ch(0, 1'b1, k);
        check("rst_redebounce", k, ON_LAT);
        check("rst_ch1_off", 32'(ch_on[1]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_ctrl.md
Name: rgb_pwm_ctrl

Overview:
- Parametrised successor to the board-level switch-to-RGB pass-through.
- Drives NUM_CH RGB LEDs, each gated by its own debounced push-button, with LVL_W-bit per-component brightness from switches via shared PWM.
- Adds hold or toggle button mode and latches colour on press, so switch changes while lit do not alter the colour.
- Sits directly under the board top level; also registers switches onto the plain LEDs.

Parameters:
- NUM_CH, 2, number of RGB LEDs / buttons.
- LVL_W, 2, brightness bits per colour component (1 = on/off only).
- PWM_W, 8, PWM counter width; requires PWM_W >= LVL_W.
- SW_W, 16, switch/LED bus width; requires 3*LVL_W*NUM_CH <= SW_W.
- DEBOUNCE_CYCLES, 1000000, stable cycles before a button change is accepted (10 ms at 100 MHz); must be >= 1.

Ports:
- clk_100mhz  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn  input  NUM_CH  raw asynchronous push-buttons, bit i = channel i
- sw  input  SW_W  raw switches
- toggle_mode  input  1  0 = hold mode, 1 = toggle mode
- rgb  output  3*NUM_CH  rgb[3i+k] = component k of channel i (k: 0=B, 1=G, 2=R)
- led  output  SW_W  registered copy of sw
- ch_on  output  NUM_CH  channel-enabled status

Behaviour:
- Interface (decided): one clock, clk_100mhz; reset rst is synchronous and active-high.
- Reset state: rgb=0, led=0, ch_on=0, latched colours=0, PWM counter=0, debounce state/counters=0, synchroniser flops=0.
- led: led <= sw every cycle; 1-cycle latency.
- Synchroniser: btn passes through 2 flops → btn_s.
- Debounce, per channel, state stable:
  - Counter cnt increments while btn_s != stable, clears when equal.
  - When btn_s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= btn_s and cnt <= 0.
  - Any bounce restarts the count.
- press[i]: 1-cycle pulse, registered, on the cycle after stable rises. Release never produces a press pulse.
- Colour slice for channel i: sw[(i+1)*3*LVL_W-1 : i*3*LVL_W]. Component k level = slice[k*LVL_W +: LVL_W].
- Latching: on press[i], col[i] <= colour slice of the switches registered that cycle (i.e. led value). Latching is the same in both modes.
- Hold mode (toggle_mode=0): ch_on[i] = stable[i], registered.
- Toggle mode (toggle_mode=1): press[i] inverts ch_on[i]; col is still latched on every press.
- Mode change: toggle_mode is registered; when the registered value changes, all ch_on clear on the next cycle. A press coincident with a mode change is ignored, and its colour latch is still performed.
- PWM:
  - Shared free-running counter pwm_cnt, PWM_W bits, wraps from 2^PWM_W-1 to 0.
  - duty = level << (PWM_W-LVL_W).
  - Component is on when ch_on[i] && (level == all-ones || pwm_cnt < duty).
  - Level 0 is always off; maximum level is 100% on, with no glitch at wrap.
  - rgb is registered: 1 cycle after pwm_cnt/ch_on.
- Independence: channels are fully independent. Simultaneous presses on several channels are each honoured in the same cycle.
- Reset mid-operation: all state returns to reset values on the next edge; a held button must re-debounce from stable=0.

Decomposition:
- Shared package rgb_pkg:
  - localparam colour index constants RGB_B=0, RGB_G=1, RGB_R=2.
  - Mode encoding MODE_HOLD=0, MODE_TOGGLE=1.
- One sub-module, btn_debounce, per channel via generate:
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk_100mhz, rst, raw_in, stable_out, rise_pulse_out.
  - Includes the 2-flop synchroniser.
- PWM counter, latch and mode logic stay in rgb_pwm_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, PWM_W=4, LVL_W=2, NUM_CH=2):
- Reset, then sw=16'hA5F0 → led==16'hA5F0 one cycle later; rgb==0, ch_on==0 throughout.
- Hold mode: sw[5:0]=6'b11_00_01 (R=3,G=0,B=1), hold btn[0]=1 → ch_on[0] rises 2+4+1 cycles after btn. Over 16 cycles, R high 16/16, G 0/16, B 4/16. Release → rgb[2:0]==0 after debounce.
- Bounce: btn[1] toggles every 2 cycles for 20 cycles, then stays 0 → ch_on[1] never asserts, no latch.
- Toggle mode: two clean presses on btn[1] with sw[11:6]=6'b10_10_10 → after the first press, R/G/B each high 8/16. Change sw while lit → output unchanged. After the second press, ch_on[1]=0.
- Toggle mode, ch 0 on; flip toggle_mode to 0 while btn[0] is released → ch_on[0] clears within 2 cycles, rgb[2:0]==0 one cycle after.
- Assert rst for 1 cycle while both channels are lit and btn[0] is held → all outputs 0. ch_on[0] re-asserts only after the full debounce delay.
